// File: rtl/conv1d_pe_engine.sv
// Single-PE 1-D convolution engine: streams ifmap/filter taps through a MAC,
// optionally accumulates onto the existing psum, and writes saturated results.
module conv1d_pe_engine #(
  parameter int DATA_WIDTH        = 16,
  parameter int IFMAP_ADDR_WIDTH  = 5,
  parameter int FILTER_ADDR_WIDTH = 4,
  parameter int PSUM_ADDR_WIDTH   = 5,
  parameter int STRIDE_WIDTH      = 2,
  parameter int FILTER_SIZE_WIDTH = 4,
  parameter int IFMAP_SIZE_WIDTH  = 4,
  parameter int NF_WIDTH          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Start,
  input  logic [STRIDE_WIDTH-1:0]      stride,
  input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
  input  logic [IFMAP_SIZE_WIDTH-1:0]  ifmap_size,
  input  logic [NF_WIDTH-1:0]          num_filters,
  input  logic                         accumulate,
  output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_addr,
  output logic [FILTER_ADDR_WIDTH-1:0] filter_addr,
  input  logic [DATA_WIDTH-1:0]        ifmap_data,
  input  logic [DATA_WIDTH-1:0]        filter_data,
  output logic [PSUM_ADDR_WIDTH-1:0]   psum_addr,
  input  logic [DATA_WIDTH-1:0]        psum_rdata,
  output logic [DATA_WIDTH-1:0]        psum_wdata,
  output logic                         psum_we,
  output logic                         busy,
  output logic                         Done,
  output logic                         err
);

  localparam int ACC_W = 2*DATA_WIDTH + 4;
  localparam int OUT_W = IFMAP_SIZE_WIDTH + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_MAC, S_PSRD, S_PSADD, S_WRITE, S_DONE
  } state_t;

  state_t state;

  logic [STRIDE_WIDTH-1:0]      s_r;
  logic [FILTER_SIZE_WIDTH-1:0] f_r;
  logic [IFMAP_SIZE_WIDTH-1:0]  isz_r;
  logic [NF_WIDTH-1:0]          nf_r;
  logic                         acc_mode;
  logic [OUT_W-1:0]             out_r;

  logic [FILTER_SIZE_WIDTH-1:0] i_cnt;
  logic [OUT_W-1:0]             j_cnt;
  logic [NF_WIDTH-1:0]          k_cnt;
  logic signed [ACC_W-1:0]      acc;

  logic                         cfg_bad;
  logic [IFMAP_SIZE_WIDTH-1:0]  diff_n;
  logic [IFMAP_SIZE_WIDTH-1:0]  quot_n;
  logic                         tap_last, out_last, filt_last;
  logic [OUT_W-1:0]             j_nxt;
  logic [NF_WIDTH-1:0]          k_nxt;
  logic [IFMAP_ADDR_WIDTH-1:0]  tap_ifmap, nxt_ifmap;
  logic [FILTER_ADDR_WIDTH-1:0] tap_filter, nxt_filter;
  logic [PSUM_ADDR_WIDTH-1:0]   psum_calc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]      addend, acc_sum;
  logic [DATA_WIDTH-1:0]        sat_val;

  // Address arithmetic runs in the port width: the low bits of a sum or
  // product depend only on the low bits of its operands, so this equals
  // computing at full width and truncating.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    cfg_bad    = 1'b0;
    diff_n     = '0;
    quot_n     = '0;
    cfg_bad    = (f_r == '0) || (s_r == '0) || (nf_r == '0) ||
                 (OUT_W'(f_r) > OUT_W'(isz_r));
    diff_n     = isz_r - IFMAP_SIZE_WIDTH'(f_r);
    if (s_r != '0) quot_n = diff_n / IFMAP_SIZE_WIDTH'(s_r);

    tap_last   = (i_cnt == f_r - FILTER_SIZE_WIDTH'(1));
    out_last   = (j_cnt == out_r - OUT_W'(1));
    filt_last  = (k_cnt == nf_r - NF_WIDTH'(1));
    j_nxt      = out_last ? '0 : j_cnt + OUT_W'(1);
    k_nxt      = out_last ? k_cnt + NF_WIDTH'(1) : k_cnt;

    tap_ifmap  = IFMAP_ADDR_WIDTH'(j_cnt) * IFMAP_ADDR_WIDTH'(s_r)
               + IFMAP_ADDR_WIDTH'(i_cnt) + IFMAP_ADDR_WIDTH'(1);
    tap_filter = FILTER_ADDR_WIDTH'(k_cnt) * FILTER_ADDR_WIDTH'(f_r)
               + FILTER_ADDR_WIDTH'(i_cnt) + FILTER_ADDR_WIDTH'(1);
    nxt_ifmap  = IFMAP_ADDR_WIDTH'(j_nxt) * IFMAP_ADDR_WIDTH'(s_r);
    nxt_filter = FILTER_ADDR_WIDTH'(k_nxt) * FILTER_ADDR_WIDTH'(f_r);
    psum_calc  = PSUM_ADDR_WIDTH'(k_cnt) * PSUM_ADDR_WIDTH'(out_r)
               + PSUM_ADDR_WIDTH'(j_cnt);

    prod       = (2*DATA_WIDTH)'($signed(ifmap_data)) *
                 (2*DATA_WIDTH)'($signed(filter_data));
    addend     = (state == S_PSADD) ? ACC_W'($signed(psum_rdata)) : ACC_W'(prod);
    acc_sum    = acc + addend;

    if (acc_sum > SAT_MAX)      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (acc_sum < SAT_MIN) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        sat_val = acc_sum[DATA_WIDTH-1:0];
  end

  // All outputs are registered and loaded on the transition into the state
  // that presents them, so each is stable for that state's whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      s_r         <= '0;
      f_r         <= '0;
      isz_r       <= '0;
      nf_r        <= '0;
      acc_mode    <= 1'b0;
      out_r       <= '0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      k_cnt       <= '0;
      acc         <= '0;
      ifmap_addr  <= '0;
      filter_addr <= '0;
      psum_addr   <= '0;
      psum_wdata  <= '0;
      psum_we     <= 1'b0;
      busy        <= 1'b0;
      Done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; these defaults make pulses one cycle long.
      psum_we <= 1'b0;
      Done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_CHECK;
            busy     <= 1'b1;
            s_r      <= stride;
            f_r      <= filter_size;
            isz_r    <= ifmap_size;
            nf_r     <= num_filters;
            acc_mode <= accumulate;
          end
        end
        S_CHECK: begin
          i_cnt <= '0;
          j_cnt <= '0;
          k_cnt <= '0;
          acc   <= '0;
          if (cfg_bad) begin
            state <= S_DONE;
            Done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state       <= S_READ;
            err         <= 1'b0;
            out_r       <= OUT_W'(quot_n) + OUT_W'(1);
            ifmap_addr  <= '0;
            filter_addr <= '0;
          end
        end
        S_READ: state <= S_MAC;
        S_MAC: begin
          acc <= acc_sum;
          if (!tap_last) begin
            state       <= S_READ;
            i_cnt       <= i_cnt + FILTER_SIZE_WIDTH'(1);
            ifmap_addr  <= tap_ifmap;
            filter_addr <= tap_filter;
          end else if (acc_mode) begin
            state     <= S_PSRD;
            psum_addr <= psum_calc;
          end else begin
            state      <= S_WRITE;
            psum_addr  <= psum_calc;
            psum_wdata <= sat_val;
            psum_we    <= 1'b1;
          end
        end
        S_PSRD: state <= S_PSADD;
        S_PSADD: begin
          state      <= S_WRITE;
          acc        <= acc_sum;
          psum_wdata <= sat_val;
          psum_we    <= 1'b1;
        end
        S_WRITE: begin
          acc   <= '0;
          i_cnt <= '0;
          j_cnt <= j_nxt;
          k_cnt <= k_nxt;
          if (out_last && filt_last) begin
            state <= S_DONE;
            Done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            state       <= S_READ;
            ifmap_addr  <= nxt_ifmap;
            filter_addr <= nxt_filter;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_pe_engine.sv
// Directed bench for conv1d_pe_engine with behavioural synchronous-read
// scratchpads; expected psums and Done cycles are hand-computed constants.
module tb_conv1d_pe_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  stride;
  logic [3:0]  filter_size;
  logic [3:0]  ifmap_size;
  logic [1:0]  num_filters;
  logic        accumulate;
  logic [4:0]  ifmap_addr;
  logic [3:0]  filter_addr;
  logic [15:0] ifmap_data;
  logic [15:0] filter_data;
  logic [4:0]  psum_addr;
  logic [15:0] psum_rdata;
  logic [15:0] psum_wdata;
  logic        psum_we;
  logic        busy;
  logic        Done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  logic [15:0] ifmap_mem  [32];
  logic [15:0] filter_mem [16];
  logic [15:0] psum_mem   [32];

  conv1d_pe_engine dut (
    .clk(clk), .rst(rst), .Start(Start),
    .stride(stride), .filter_size(filter_size), .ifmap_size(ifmap_size),
    .num_filters(num_filters), .accumulate(accumulate),
    .ifmap_addr(ifmap_addr), .filter_addr(filter_addr),
    .ifmap_data(ifmap_data), .filter_data(filter_data),
    .psum_addr(psum_addr), .psum_rdata(psum_rdata),
    .psum_wdata(psum_wdata), .psum_we(psum_we),
    .busy(busy), .Done(Done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifmap_data  <= ifmap_mem[ifmap_addr];
    filter_data <= filter_mem[filter_addr];
    psum_rdata  <= psum_mem[psum_addr];
    if (psum_we) begin
      psum_mem[psum_addr] = psum_wdata;
      we_count = we_count + 1;
    end
  end

  task automatic fill_mems(input logic [15:0] iv, input logic [15:0] fv, input logic [15:0] pv);
    for (int a = 0; a < 32; a++) ifmap_mem[a] = iv;
    for (int a = 0; a < 16; a++) filter_mem[a] = fv;
    for (int a = 0; a < 32; a++) psum_mem[a] = pv;
  endtask

  task automatic load_basic();
    fill_mems(16'd0, 16'd0, 16'h5555);
    for (int a = 0; a < 5; a++) ifmap_mem[a] = 16'(a + 1);
    for (int a = 0; a < 3; a++) filter_mem[a] = 16'd1;
  endtask

  task automatic drive_start(input int i_sz, input int f_sz, input int s, input int nf, input logic accm);
    @(negedge clk);
    ifmap_size  = 4'(i_sz);
    filter_size = 4'(f_sz);
    stride      = 2'(s);
    num_filters = 2'(nf);
    accumulate  = accm;
    Start       = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Cycle n is the period ending at the n-th edge after the Start-sampling edge.
  task automatic run_job(input int i_sz, input int f_sz, input int s, input int nf,
                         input logic accm, output int cyc, output logic e);
    drive_start(i_sz, f_sz, s, nf, accm);
    cyc = 0;
    e   = 1'bx;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (Done) begin
        e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; stride = 2'd1; filter_size = 4'd3;
    ifmap_size = 4'd5; num_filters = 2'd1; accumulate = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", Done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (psum_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", psum_we); end
    checks++;
    if ({ifmap_addr, filter_addr, psum_addr, psum_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_addr got if=%0d f=%0d p=%0d wd=%0d exp all 0",
               ifmap_addr, filter_addr, psum_addr, psum_wdata);
    end
    Start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_prio_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    int cyc; logic e; int wc0;
    logic [15:0] exp_p [4];
    exp_p = '{16'd6, 16'd9, 16'd12, 16'h5555};
    load_basic();
    wc0 = we_count;
    run_job(5, 3, 1, 1, 1'b0, cyc, e);
    checks++; if (cyc !== 23) begin failures++; $display("FAIL basic_cycle got %0d exp 23", cyc); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_err got %b exp 0", e); end
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (psum_mem[a] !== exp_p[a]) begin
        failures++; $display("FAIL basic_psum%0d got %0d exp %0d", a, psum_mem[a], exp_p[a]);
      end
    end
    checks++; if (we_count - wc0 !== 3) begin failures++; $display("FAIL basic_wecount got %0d exp 3", we_count - wc0); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || Done !== 1'b0) begin
      failures++; $display("FAIL basic_idle got busy=%b done=%b exp 0 0", busy, Done);
    end
  endtask

  task automatic test_stride_multi();
    int cyc; logic e;
    logic [15:0] exp_p [6];
    exp_p = '{16'd6, 16'd6, 16'd6, 16'd12, 16'd12, 16'd12};
    fill_mems(16'd0, 16'd0, 16'd0);
    for (int a = 0; a < 10; a++) ifmap_mem[a] = 16'd1;
    for (int a = 0; a < 6; a++) filter_mem[a] = 16'd1;
    for (int a = 6; a < 12; a++) filter_mem[a] = 16'd2;
    run_job(10, 6, 2, 2, 1'b0, cyc, e);
    checks++; if (cyc !== 80) begin failures++; $display("FAIL stride_cycle got %0d exp 80", cyc); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL stride_err got %b exp 0", e); end
    for (int a = 0; a < 6; a++) begin
      checks++;
      if (psum_mem[a] !== exp_p[a]) begin
        failures++; $display("FAIL stride_psum%0d got %0d exp %0d", a, psum_mem[a], exp_p[a]);
      end
    end
  endtask

  task automatic test_errors();
    int cyc; logic e; int wc0;
    int cfg [4][4];
    // {I, F, S, NF}: F>I, S=0, F=0, NF=0
    cfg = '{'{5, 6, 1, 1}, '{5, 3, 0, 1}, '{5, 0, 1, 1}, '{5, 3, 1, 0}};
    load_basic();
    for (int t = 0; t < 4; t++) begin
      wc0 = we_count;
      run_job(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3], 1'b0, cyc, e);
      checks++; if (cyc !== 2) begin failures++; $display("FAIL err%0d_cycle got %0d exp 2", t, cyc); end
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL err%0d_flag got %b exp 1", t, e); end
      @(negedge clk);
      checks++; if (we_count !== wc0) begin failures++; $display("FAIL err%0d_we got %0d writes exp 0", t, we_count - wc0); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_after_done got %b exp 0", err); end
  endtask

  task automatic test_saturation();
    int cyc; logic e;
    logic [15:0] vin  [4][2];
    logic [15:0] vflt [4][2];
    logic [15:0] vexp [4];
    vin  = '{'{16'h7FFF, 16'h7FFF}, '{16'h7FFF, 16'h7FFF}, '{16'h8000, 16'h8000}, '{16'h7FFF, 16'h0000}};
    vflt = '{'{16'h0001, 16'h0001}, '{16'hFFFF, 16'hFFFF}, '{16'h0001, 16'h0001}, '{16'hFFFF, 16'hFFFF}};
    // 65534 -> 32767; -65534 -> -32768; -65536 -> -32768; -32767 stays in range
    vexp = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8001};
    for (int t = 0; t < 4; t++) begin
      fill_mems(16'd0, 16'd0, 16'h1234);
      ifmap_mem[0] = vin[t][0];  ifmap_mem[1] = vin[t][1];
      filter_mem[0] = vflt[t][0]; filter_mem[1] = vflt[t][1];
      run_job(2, 2, 1, 1, 1'b0, cyc, e);
      checks++; if (cyc !== 7) begin failures++; $display("FAIL sat%0d_cycle got %0d exp 7", t, cyc); end
      checks++;
      if (psum_mem[0] !== vexp[t]) begin
        failures++; $display("FAIL sat%0d_psum got %h exp %h", t, psum_mem[0], vexp[t]);
      end
    end
  endtask

  task automatic test_accumulate();
    int cyc; logic e;
    logic [15:0] exp_p [4];
    exp_p = '{16'd106, 16'd109, 16'd112, 16'd100};
    load_basic();
    for (int a = 0; a < 4; a++) psum_mem[a] = 16'd100;
    run_job(5, 3, 1, 1, 1'b1, cyc, e);
    checks++; if (cyc !== 29) begin failures++; $display("FAIL acc_cycle got %0d exp 29", cyc); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL acc_err got %b exp 0", e); end
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (psum_mem[a] !== exp_p[a]) begin
        failures++; $display("FAIL acc_psum%0d got %0d exp %0d", a, psum_mem[a], exp_p[a]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int cyc; logic e; int wc0;
    logic [15:0] exp_p [3];
    exp_p = '{16'd6, 16'd9, 16'd12};
    load_basic();
    drive_start(5, 3, 1, 1, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wc0 = we_count;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got %b exp 0", busy); end
    checks++; if (psum_we !== 1'b0) begin failures++; $display("FAIL mid_we_after got %b exp 0", psum_we); end
    repeat (20) @(negedge clk);
    checks++; if (we_count !== wc0) begin failures++; $display("FAIL mid_no_write got %0d writes exp 0", we_count - wc0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_stays_idle got %b exp 0", busy); end
    load_basic();
    run_job(5, 3, 1, 1, 1'b0, cyc, e);
    checks++; if (cyc !== 23) begin failures++; $display("FAIL mid_rerun_cycle got %0d exp 23", cyc); end
    for (int a = 0; a < 3; a++) begin
      checks++;
      if (psum_mem[a] !== exp_p[a]) begin
        failures++; $display("FAIL mid_rerun_psum%0d got %0d exp %0d", a, psum_mem[a], exp_p[a]);
      end
    end
  endtask

  initial begin
    fill_mems(16'd0, 16'd0, 16'd0);
    test_reset();
    test_basic();
    test_stride_multi();
    test_errors();
    test_saturation();
    test_accumulate();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
